core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: none; state encoding fixed: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, HALT=5.
REQ-002 clk  input  1  core clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 imem_ack  input  1  instruction word valid on instr bus this cycle.
REQ-005 mem_read, mem_write  input  1 each  load/store flags from decode stage.
REQ-006 data_in, data_out  input  1 each  input/output instruction flags from decode stage.
REQ-007 dmem_ack  input  1  data memory access complete.
REQ-008 in_valid  input  1  input FIFO holds a byte.
REQ-009 out_ready  input  1  output FIFO can accept a byte.
REQ-010 halt_req  input  1  level; stop after current instruction retires.
REQ-011 resume  input  1  pulse; leave HALT.
REQ-012 state  output  3  current phase, drives decode/exec/mem/write stages.
REQ-013 imem_req  output  1  instruction fetch request.
REQ-014 ir_we  output  1  latch instruction register.
REQ-015 dmem_req  output  1  data memory request.
REQ-016 in_pop  output  1  consume one input byte.
REQ-017 out_push  output  1  emit one output byte.
REQ-018 pc_we  output  1  commit next PC.
REQ-019 halted  output  1  core in HALT.
REQ-020 instret  output  32  retired-instruction counter.
REQ-021 stall_cnt  output  32  cycles spent waiting on any handshake.

Function
REQ-022 FETCH: imem_req=1 combinationally; on imem_ack: ir_we=1 for that cycle, next state DECODE; otherwise stay (stall).
REQ-023 DECODE: exactly one cycle, next state EXEC; all handshake outputs 0.
REQ-024 EXEC, data_in=1: if in_valid, in_pop=1 for one cycle, next WRITE; else stay, in_pop=0.
REQ-025 EXEC, data_out=1: if out_ready, out_push=1 for one cycle, next WRITE; else stay.
REQ-026 EXEC, data_in and data_out both 1: data_in rule takes priority; out_push never asserted.
REQ-027 EXEC, mem_read or mem_write (no I/O flag): next MEM, no stall.
REQ-028 EXEC, none of the above: next WRITE.
REQ-029 MEM: dmem_req=1 held every cycle until dmem_ack sampled 1; then next WRITE; dmem_req 0 in all other states.
REQ-030 WRITE: pc_we=1, instret increments by 1 (wraps 2^32-1 -> 0); next HALT if halt_req=1, else FETCH.
REQ-031 halt_req in any non-WRITE state has no effect until WRITE; instruction in flight always completes.
REQ-032 HALT: halted=1, all other strobes 0; on resume=1 next FETCH; resume outside HALT ignored.
REQ-033 stall_cnt increments (wrapping) each cycle the FSM stays in FETCH, EXEC or MEM because its awaited handshake is 0.
REQ-034 imem_ack outside FETCH, dmem_ack outside MEM ignored.
REQ-035 Minimal instruction latency: non-memory, non-I/O = 4 cycles with imem_ack in first FETCH cycle; load/store = 5 cycles with immediate dmem_ack.
REQ-036 Encodings 6,7 unreachable; if entered, next state FETCH.

Reset
REQ-037 While rst=0: state=FETCH(0), instret=0, stall_cnt=0, halted=0; ir_we, dmem_req, in_pop, out_push, pc_we=0 immediately, without clock.
REQ-038 imem_req=1 one combinational delay after state=FETCH, including during reset.
REQ-039 Reset mid-MEM or mid-stall aborts the access; no pc_we, no instret increment for that instruction.
REQ-040 First rising edge after rst rises evaluates FETCH normally.

Verification
REQ-041 ALU instr, imem_ack held 1 -> state 0,1,2,4,0; pc_we one cycle; instret 0->1; stall_cnt 0.
REQ-042 Load, dmem_ack asserted 3 cycles after MEM entry -> dmem_req high 4 cycles, stall_cnt=3, then WRITE.
REQ-043 data_in=1, in_valid low 5 cycles then high -> EXEC held 6 cycles, in_pop exactly one pulse, stall_cnt=5.
REQ-044 halt_req raised during DECODE -> instruction retires (instret+1), state 5, halted=1; resume pulse -> FETCH next cycle.
REQ-045 rst low during MEM with dmem_req=1 -> dmem_req, pc_we 0 asynchronously, state=0, instret unchanged from 0.
REQ-046 instret preloaded by running 2^32-1 retirements (or forced) -> next WRITE wraps to 0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/write phase sequencer with halt, retire and stall counters.
module core_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        data_in,
  input  logic        data_out,
  input  logic        dmem_ack,
  input  logic        in_valid,
  input  logic        out_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic [2:0]  state,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        in_pop,
  output logic        out_push,
  output logic        pc_we,
  output logic        halted,
  output logic [31:0] instret,
  output logic [31:0] stall_cnt
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t cur, nxt;
  logic stall;
  assign state    = cur;
  assign imem_req = cur == FETCH;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= FETCH;
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      cur <= nxt;
      if (pc_we) instret <= instret + 32'd1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  // strobes are gated by rst so they drop the moment reset asserts, without a clock
  always_comb begin
    nxt      = cur;
    stall    = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    in_pop   = 1'b0;
    out_push = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    if (rst) begin
      case (cur)
        FETCH: begin
          ir_we = imem_ack;
          stall = !imem_ack;
          nxt   = imem_ack ? DECODE : FETCH;
        end
        DECODE: nxt = EXEC;
        EXEC: begin
          if (data_in) begin
            in_pop = in_valid;
            stall  = !in_valid;
            nxt    = in_valid ? WRITE : EXEC;
          end else if (data_out) begin
            out_push = out_ready;
            stall    = !out_ready;
            nxt      = out_ready ? WRITE : EXEC;
          end else begin
            nxt = (mem_read || mem_write) ? MEM : WRITE;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          stall    = !dmem_ack;
          nxt      = dmem_ack ? WRITE : MEM;
        end
        WRITE: begin
          pc_we = 1'b1;
          nxt   = halt_req ? HALT : FETCH;
        end
        HALT: begin
          halted = 1'b1;
          nxt    = resume ? FETCH : HALT;
        end
        default: nxt = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven vectors plus directed reset/halt/wrap sequences.
module tb_core_sequencer;
  logic clk = 1'b0, rst = 1'b0;
  logic imem_ack = 0, mem_read = 0, mem_write = 0, data_in = 0, data_out = 0;
  logic dmem_ack = 0, in_valid = 0, out_ready = 0, halt_req = 0, resume = 0;
  logic [2:0] state;
  logic imem_req, ir_we, dmem_req, in_pop, out_push, pc_we, halted;
  logic [31:0] instret, stall_cnt;
  core_sequencer dut (
    .clk(clk), .rst(rst), .imem_ack(imem_ack), .mem_read(mem_read), .mem_write(mem_write),
    .data_in(data_in), .data_out(data_out), .dmem_ack(dmem_ack), .in_valid(in_valid),
    .out_ready(out_ready), .halt_req(halt_req), .resume(resume), .state(state),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .in_pop(in_pop),
    .out_push(out_push), .pc_we(pc_we), .halted(halted), .instret(instret), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // strobe order: imem_req ir_we dmem_req in_pop out_push pc_we halted
  wire [6:0] strobes = {imem_req, ir_we, dmem_req, in_pop, out_push, pc_we, halted};
  // input order: imem_ack mem_read mem_write data_in data_out dmem_ack in_valid out_ready halt_req resume
  typedef struct {
    logic [9:0]  in;
    logic [2:0]  st;
    logic [6:0]  out;
    logic [31:0] ir;
    logic [31:0] sc;
  } vec_t;
  vec_t vecs[$];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [9:0] v);
    {imem_ack, mem_read, mem_write, data_in, data_out, dmem_ack, in_valid, out_ready, halt_req, resume} = v;
  endtask
  task automatic add(input logic [9:0] in, input logic [2:0] st, input logic [6:0] out,
                     input int ir, input int sc);
    vec_t v;
    v.in = in; v.st = st; v.out = out; v.ir = ir; v.sc = sc;
    vecs.push_back(v);
  endtask
  initial begin
    // ALU instruction, imem_ack held high
    add(10'b1000000000, 0, 7'b1100000, 0, 0);
    add(10'b1000000000, 1, 7'b0000000, 0, 0);
    add(10'b0000000000, 2, 7'b0000000, 0, 0);
    add(10'b0000000000, 4, 7'b0000010, 0, 0);
    // load, dmem_ack three cycles after MEM entry (early ack in EXEC ignored)
    add(10'b1100000000, 0, 7'b1100000, 1, 0);
    add(10'b0100000000, 1, 7'b0000000, 1, 0);
    add(10'b0100010000, 2, 7'b0000000, 1, 0);
    add(10'b0100000000, 3, 7'b0010000, 1, 0);
    add(10'b0100000000, 3, 7'b0010000, 1, 1);
    add(10'b0100000000, 3, 7'b0010000, 1, 2);
    add(10'b0100010000, 3, 7'b0010000, 1, 3);
    add(10'b0000000000, 4, 7'b0000010, 1, 3);
    // input with in_valid low five cycles
    add(10'b1001000000, 0, 7'b1100000, 2, 3);
    add(10'b0001000000, 1, 7'b0000000, 2, 3);
    for (int k = 0; k < 5; k++) add(10'b0001000000, 2, 7'b0000000, 2, 3 + k);
    add(10'b0001001000, 2, 7'b0001000, 2, 8);
    add(10'b0000000000, 4, 7'b0000010, 2, 8);
    // input and output together: input rule wins even with out_ready
    add(10'b1000000000, 0, 7'b1100000, 3, 8);
    add(10'b0001100000, 1, 7'b0000000, 3, 8);
    add(10'b0001100100, 2, 7'b0000000, 3, 8);
    add(10'b0001101100, 2, 7'b0001000, 3, 9);
    add(10'b0000000000, 4, 7'b0000010, 3, 9);
    // output only
    add(10'b1000000000, 0, 7'b1100000, 4, 9);
    add(10'b0000100000, 1, 7'b0000000, 4, 9);
    add(10'b0000100000, 2, 7'b0000000, 4, 9);
    add(10'b0000100100, 2, 7'b0000100, 4, 10);
    add(10'b0000000000, 4, 7'b0000010, 4, 10);
    // halt_req held across the instruction, honoured only in WRITE
    add(10'b1000000010, 0, 7'b1100000, 5, 10);
    add(10'b0000000010, 1, 7'b0000000, 5, 10);
    add(10'b0000000010, 2, 7'b0000000, 5, 10);
    add(10'b0000000010, 4, 7'b0000010, 5, 10);
    add(10'b1000000000, 5, 7'b0000001, 6, 10);
    add(10'b0000000001, 5, 7'b0000001, 6, 10);
    add(10'b0000000000, 0, 7'b1000000, 6, 10);
    // store with immediate ack, stray resume in WRITE ignored
    add(10'b1000000000, 0, 7'b1100000, 6, 11);
    add(10'b0010010000, 1, 7'b0000000, 6, 11);
    add(10'b0010010000, 2, 7'b0000000, 6, 11);
    add(10'b0010010000, 3, 7'b0010000, 6, 11);
    add(10'b0000000001, 4, 7'b0000010, 6, 11);
    add(10'b0000000000, 0, 7'b1000000, 7, 11);

    drive(10'b1000000000);
    #1;
    chk("rst.state", state, 0);
    chk("rst.strobes", strobes, 7'b1000000);
    @(posedge clk); #1;
    chk("rst.state_clk", state, 0);
    chk("rst.instret", instret, 0);
    chk("rst.stall", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      #1;
      chk($sformatf("v%0d.state", i), state, vecs[i].st);
      chk($sformatf("v%0d.strobes", i), strobes, vecs[i].out);
      chk($sformatf("v%0d.instret", i), instret, vecs[i].ir);
      chk($sformatf("v%0d.stall", i), stall_cnt, vecs[i].sc);
      @(negedge clk);
    end

    // reset during a stalled MEM access
    drive(10'b1100000000);
    @(negedge clk); drive(10'b0100000000);
    @(negedge clk);
    @(negedge clk); #1;
    chk("mem.state", state, 3);
    chk("mem.dmem_req", dmem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst.dmem_req", dmem_req, 0);
    chk("arst.pc_we", pc_we, 0);
    chk("arst.state", state, 0);
    chk("arst.instret", instret, 0);
    drive(10'b0100010000);
    @(posedge clk); #1;
    chk("arst.hold_instret", instret, 0);
    chk("arst.hold_strobes", strobes, 7'b1000000);
    @(negedge clk);
    rst = 1'b1;
    drive(10'b1000000000);
    #1;
    chk("rel.ir_we", ir_we, 1);
    @(negedge clk); drive(10'b0000000000); #1;
    chk("rel.decode", state, 1);
    @(negedge clk); @(negedge clk); #1;
    chk("rel.write", state, 4);
    @(negedge clk); #1;
    chk("rel.instret", instret, 1);

    // retire counter wrap
    force dut.instret = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret;
    #1;
    chk("wrap.pre", instret, 32'hFFFF_FFFF);
    drive(10'b1000000000);
    @(negedge clk); drive(10'b0000000000);
    @(negedge clk);
    @(negedge clk); #1;
    chk("wrap.write", state, 4);
    @(negedge clk); #1;
    chk("wrap.instret", instret, 0);
    chk("wrap.state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
